mc_control: RTL and testbench

Multicycle main control FSM for the datapath. Decodes the 6-bit instruction opcode from the instruction register. Sequences each instruction through fetch, decode, execute, memory and writeback states. Drives the 3-bit ALU operation code consumed by the ALU controller, plus all datapath mux, enable and memory strobes, stalling on a memory-ready handshake.

---
 rtl/mc_control.sv | 135 +++++++++++++
 tb/tb_mc_control.sv | 124 ++++++++++++
 2 files changed

// File: rtl/mc_control.sv
// mc_control: multicycle main control FSM with memory-ready stalls.
// Define ILLEGAL_OP_TRAP_EN to trap unknown opcodes until reset instead of treating them as no-ops.
module mc_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       memrdy,
  output logic       memread,
  output logic       memwrite,
  output logic       iord,
  output logic       irwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic       aluop2,
  output logic       aluop1,
  output logic       aluop0,
  output logic       illegal
);
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000,
                         OP_ANDI = 6'b001100, OP_ORI = 6'b001101;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, REXEC, RWB, BEQEX, IEXEC, IWB, JEX
`ifdef ILLEGAL_OP_TRAP_EN
    , TRAP
`endif
  } state_t;
  state_t state;
  logic [2:0] aluop;
  assign {aluop2, aluop1, aluop0} = aluop;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= FETCH;
    else
      case (state)
        FETCH:  if (memrdy) state <= DECODE;
        DECODE:
          case (opcode)
            OP_LW, OP_SW:              state <= MEMADR;
            OP_R:                      state <= REXEC;
            OP_BEQ:                    state <= BEQEX;
            OP_J:                      state <= JEX;
            OP_ADDI, OP_ANDI, OP_ORI:  state <= IEXEC;
`ifdef ILLEGAL_OP_TRAP_EN
            default:                   state <= TRAP;
`else
            default:                   state <= FETCH;
`endif
          endcase
        MEMADR: state <= opcode == OP_LW ? MEMRD : MEMWR;
        MEMRD:  if (memrdy) state <= MEMWB;
        MEMWR:  if (memrdy) state <= FETCH;
        REXEC:  state <= RWB;
        IEXEC:  state <= IWB;
`ifdef ILLEGAL_OP_TRAP_EN
        TRAP:   state <= TRAP;
`endif
        default: state <= FETCH;
      endcase
  // Outputs are gated by rst_n so that nothing strobes while reset is held.
  always_comb begin
    memread = 1'b0;
    memwrite = 1'b0;
    iord = 1'b0;
    irwrite = 1'b0;
    regwrite = 1'b0;
    regdst = 1'b0;
    memtoreg = 1'b0;
    alusrca = 1'b0;
    alusrcb = 2'b00;
    pcsrc = 2'b00;
    pcen = 1'b0;
    aluop = 3'b000;
    illegal = 1'b0;
    if (rst_n)
      case (state)
        FETCH: begin
          memread = 1'b1;
          alusrcb = 2'b01;
          irwrite = memrdy;
          pcen = memrdy;
        end
        DECODE: alusrcb = 2'b11;
        MEMADR: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
        end
        MEMRD: begin
          memread = 1'b1;
          iord = 1'b1;
        end
        MEMWB: begin
          regwrite = 1'b1;
          memtoreg = 1'b1;
        end
        MEMWR: begin
          memwrite = 1'b1;
          iord = 1'b1;
        end
        REXEC: begin
          alusrca = 1'b1;
          aluop = 3'b100;
        end
        RWB: begin
          regwrite = 1'b1;
          regdst = 1'b1;
        end
        BEQEX: begin
          alusrca = 1'b1;
          aluop = 3'b001;
          pcsrc = 2'b01;
          pcen = zero;
        end
        IEXEC: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
          aluop = opcode == OP_ANDI ? 3'b010 : opcode == OP_ORI ? 3'b011 : 3'b000;
        end
        IWB: regwrite = 1'b1;
        JEX: begin
          pcsrc = 2'b10;
          pcen = 1'b1;
        end
`ifdef ILLEGAL_OP_TRAP_EN
        TRAP: illegal = 1'b1;
`endif
        default: ;
      endcase
  end
endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: randomized check of mc_control against a phase-table model of the instruction flow.
module tb_mc_control;
  logic clk = 1'b0, rst_n = 1'b0, zero = 1'b0, memrdy = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic memread, memwrite, iord, irwrite, regwrite, regdst, memtoreg, alusrca, pcen;
  logic aluop2, aluop1, aluop0, illegal;
  logic [1:0] alusrcb, pcsrc;
  logic [16:0] got;
  int checks = 0, errors = 0;
  mc_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .memrdy(memrdy),
    .memread(memread), .memwrite(memwrite), .iord(iord), .irwrite(irwrite),
    .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .pcen(pcen), .aluop2(aluop2), .aluop1(aluop1),
    .aluop0(aluop0), .illegal(illegal)
  );
  assign got = {memread, memwrite, iord, irwrite, regwrite, regdst, memtoreg, alusrca,
                alusrcb, pcsrc, pcen, aluop2, aluop1, aluop0, illegal};
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [16:0] act, input logic [16:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  // Expected outputs for one cycle spent in a named instruction phase.
  function automatic logic [16:0] model(string ph, logic [5:0] op, logic z, logic mr);
    logic mrd = 0, mwr = 0, io = 0, irw = 0, rw = 0, rd = 0, m2r = 0, sa = 0, pe = 0, ill = 0;
    logic [1:0] sb = 0, ps = 0;
    logic [2:0] al = 0;
    case (ph)
      "FETCH":  begin mrd = 1; sb = 2'b01; irw = mr; pe = mr; end
      "DECODE": sb = 2'b11;
      "MEMADR": begin sa = 1; sb = 2'b10; end
      "MEMRD":  begin mrd = 1; io = 1; end
      "MEMWB":  begin rw = 1; m2r = 1; end
      "MEMWR":  begin mwr = 1; io = 1; end
      "REXEC":  begin sa = 1; al = 3'b100; end
      "RWB":    begin rw = 1; rd = 1; end
      "BEQEX":  begin sa = 1; al = 3'b001; ps = 2'b01; pe = z; end
      "IEXEC":  begin sa = 1; sb = 2'b10; al = op == 6'b001100 ? 3'b010 : op == 6'b001101 ? 3'b011 : 3'b000; end
      "IWB":    rw = 1;
      "JEX":    begin ps = 2'b10; pe = 1; end
      "TRAP":   ill = 1;
      default: ;
    endcase
    return {mrd, mwr, io, irw, rw, rd, m2r, sa, sb, ps, pe, al, ill};
  endfunction
  task automatic reset_pulse(input string tag);
    rst_n = 1'b0;
    #1 check({tag, "_rst_now"}, got, 17'd0);
    memrdy = 1'b1;
    @(negedge clk);
    check({tag, "_rst_hold"}, got, 17'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask
  // Runs one instruction starting in FETCH at posedge+1; stall < 0 picks random wait cycles.
  task automatic run(input logic [5:0] op, input int stall, input int zf, input bit abort);
    string ph[$];
    bit trapped = 0;
    opcode = op;
    ph = {"FETCH", "DECODE"};
    case (op)
      6'b100011: ph = {ph, "MEMADR", "MEMRD", "MEMWB"};
      6'b101011: ph = {ph, "MEMADR", "MEMWR"};
      6'b000000: ph = {ph, "REXEC", "RWB"};
      6'b000100: ph = {ph, "BEQEX"};
      6'b000010: ph = {ph, "JEX"};
      6'b001000, 6'b001100, 6'b001101: ph = {ph, "IEXEC", "IWB"};
`ifdef ILLEGAL_OP_TRAP_EN
      default: begin ph = {ph, "TRAP"}; trapped = 1; end
`else
      default: ;
`endif
    endcase
    foreach (ph[k]) begin
      bit memph = ph[k] == "FETCH" || ph[k] == "MEMRD" || ph[k] == "MEMWR";
      int n = memph ? (stall < 0 ? int'($urandom_range(0, 2)) : stall) + 1 : ph[k] == "TRAP" ? 4 : 1;
      for (int i = 0; i < n; i++) begin
        memrdy = memph ? (i == n - 1) : 1'($urandom);
        zero = zf < 0 ? 1'($urandom) : 1'(zf);
        if (abort && ph[k] == "MEMWR" && i == 1) begin
          reset_pulse("abort");
          return;
        end
        @(negedge clk);
        check(ph[k], got, model(ph[k], op, zero, memrdy));
        @(posedge clk);
        #1;
      end
    end
    if (trapped) reset_pulse("trap");
  endtask
  initial begin
    logic [5:0] ops [8] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                            6'b000010, 6'b001000, 6'b001100, 6'b001101};
    memrdy = 1'b1;
    @(negedge clk);
    check("reset0", got, 17'd0);
    zero = 1'b1;
    @(negedge clk);
    check("reset1", got, 17'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    run(6'b100011, 0, -1, 0);
    run(6'b000000, 0, -1, 0);
    run(6'b000100, 0, 1, 0);
    run(6'b000100, 0, 0, 0);
    run(6'b001101, 0, -1, 0);
    run(6'b001100, 0, -1, 0);
    run(6'b001000, 0, -1, 0);
    run(6'b101011, 3, -1, 0);
    run(6'b101011, 3, -1, 1);
    run(6'b000010, 0, -1, 0);
    run(6'b111111, 0, -1, 0);
    run(6'b100011, 2, -1, 0);
    for (int t = 0; t < 80; t++)
      run($urandom_range(0, 5) == 0 ? 6'($urandom) : ops[$urandom_range(0, 7)], -1, -1, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
